// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives a synchronous instruction memory and feeds decode through a
// 2-entry {pc, inst} buffer, suspending sequential fetch after a jump until decode redirects.
module inst_fetch #(
    parameter int unsigned       INST_W   = 16,
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        JUMP_OP  = 4'b1000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              jump_wait
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend_pc;
    logic              r_pending;
    logic              r_jump_wait;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_fifo_pc   [2];
    logic [INST_W-1:0] r_fifo_inst [2];

    logic              w_pop;
    logic              w_push;
    logic              w_is_jump;
    logic              w_redirect;
    logic              w_issue;
    logic              w_wr_hi;
    logic [2:0]        w_occupancy;

    always_comb begin
        id_valid    = (r_count != 2'd0);
        w_pop       = id_valid & id_ready;
        // A response that arrives while suspended belongs to the fall-through path.
        w_push      = r_pending & ~r_jump_wait;
        w_is_jump   = w_push & (imem_rdata[INST_W-1 -: 4] == JUMP_OP);
        w_redirect  = redirect_valid & r_jump_wait;
        // Words held plus the one in flight, after this cycle's pop: a new request must fit.
        w_occupancy = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
        w_issue     = ~rst & ~r_jump_wait & (w_occupancy < 3'd2);
        w_wr_hi     = ((r_count - {1'b0, w_pop}) != 2'd0);
    end

    assign imem_en   = w_issue;
    assign imem_addr = r_pc;
    assign jump_wait = r_jump_wait;
    assign id_inst   = id_valid ? r_fifo_inst[0] : '0;
    assign id_pc     = id_valid ? r_fifo_pc[0]   : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_pend_pc   <= '0;
            r_pending   <= 1'b0;
            r_jump_wait <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_redirect) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
            if (w_issue) begin
                r_pend_pc <= r_pc;
            end
            r_pending <= w_issue;
            if (w_redirect) begin
                r_jump_wait <= 1'b0;
            end else if (w_is_jump) begin
                r_jump_wait <= 1'b1;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 down so order is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_pc[0]   <= '0;
            r_fifo_pc[1]   <= '0;
            r_fifo_inst[0] <= '0;
            r_fifo_inst[1] <= '0;
        end else begin
            if (w_push && !w_wr_hi) begin
                r_fifo_pc[0]   <= r_pend_pc;
                r_fifo_inst[0] <= imem_rdata;
            end else if (w_pop) begin
                r_fifo_pc[0]   <= r_fifo_pc[1];
                r_fifo_inst[0] <= r_fifo_inst[1];
            end
            if (w_push && w_wr_hi) begin
                r_fifo_pc[1]   <= r_pend_pc;
                r_fifo_inst[1] <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && !w_pop && (r_count == 2'd2)))
            else $error("inst_fetch: push into full buffer");
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: scoreboard of expected {pc, inst} words checked at each
// decode handshake, plus point checks on fetch control timing.
module tb_inst_fetch;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] inst;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        id_valid;
    logic [15:0] id_inst;
    logic [7:0]  id_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        jump_wait;

    logic        rst_b;
    logic        imem_en_b;
    logic [7:0]  imem_addr_b;
    logic [15:0] imem_rdata_b;
    logic        id_valid_b;
    logic [15:0] id_inst_b;
    logic [7:0]  id_pc_b;
    logic        id_ready_b;
    logic        jump_wait_b;

    logic [15:0] mem [256];
    sb_t         q_a[$];
    sb_t         q_b[$];
    sb_t         e_a;
    sb_t         e_b;
    int          n_checks = 0;
    int          n_fail   = 0;

    inst_fetch #(.INST_W(16), .ADDR_W(8), .RESET_PC(8'h00), .JUMP_OP(4'b1000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .jump_wait      (jump_wait)
    );

    inst_fetch #(.INST_W(16), .ADDR_W(8), .RESET_PC(8'hFE), .JUMP_OP(4'b1000)) dut_b (
        .clk            (clk),
        .rst            (rst_b),
        .imem_en        (imem_en_b),
        .imem_addr      (imem_addr_b),
        .imem_rdata     (imem_rdata_b),
        .id_valid       (id_valid_b),
        .id_inst        (id_inst_b),
        .id_pc          (id_pc_b),
        .id_ready       (id_ready_b),
        .redirect_valid (1'b0),
        .redirect_pc    (8'h00),
        .jump_wait      (jump_wait_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
        if (imem_en_b) imem_rdata_b <= {8'h00, imem_addr_b};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input bit sel_b);
        return sel_b ? q_b.size() : q_a.size();
    endfunction

    // Returns at negedge+2 once the scoreboard holds at most 'level' words.
    task automatic wait_level(input string tag, input bit sel_b, input int level, input int budget);
        int n;
        n = 0;
        while (qsize(sel_b) > level && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk(tag, 32'(qsize(sel_b)), 32'(level));
    endtask

    task automatic push_a(input logic [7:0] pc);
        q_a.push_back('{pc: pc, inst: mem[pc]});
    endtask

    always @(negedge clk) begin
        if (id_valid && id_ready) begin
            chk("a_word_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                e_a = q_a.pop_front();
                chk("a_id_pc", 32'(id_pc), 32'(e_a.pc));
                chk("a_id_inst", 32'(id_inst), 32'(e_a.inst));
            end
        end
        if (id_valid_b && id_ready_b) begin
            chk("b_word_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                e_b = q_b.pop_front();
                chk("b_id_pc", 32'(id_pc_b), 32'(e_b.pc));
                chk("b_id_inst", 32'(id_inst_b), 32'(e_b.inst));
            end
        end
    end

    initial begin
        rst = 1'b1;
        rst_b = 1'b1;
        id_ready = 1'b0;
        id_ready_b = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h00);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_inst", 32'(id_inst), 32'd0);
        chk("rst_id_pc", 32'(id_pc), 32'd0);
        chk("rst_jump_wait", 32'(jump_wait), 32'd0);
        chk("rst_b_imem_addr", 32'(imem_addr_b), 32'hFE);
        chk("rst_b_imem_en", 32'(imem_en_b), 32'd0);

        // Streaming from reset, then a 5-cycle decode stall.
        for (int i = 0; i < 20; i++) push_a(8'(i));
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        chk("first_imem_en", 32'(imem_en), 32'd1);
        chk("first_imem_addr", 32'(imem_addr), 32'h00);
        @(negedge clk);
        chk("latency_not_yet", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(id_valid), 32'd1);

        wait_level("drain_to_stall", 1'b0, 10, 40);
        @(posedge clk);
        #1;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_imem_en", 32'(imem_en), 32'd0);
            chk("stall_id_valid", 32'(id_valid), 32'd1);
            chk("stall_head_pc", 32'(id_pc), 32'(q_a[0].pc));
        end
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        @(negedge clk);
        chk("resume_imem_en", 32'(imem_en), 32'd1);
        wait_level("drain_stream", 1'b0, 0, 40);

        // Reset pulse between edges while streaming with a request in flight.
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_id_valid", 32'(id_valid), 32'd0);
        chk("midrst_imem_en", 32'(imem_en), 32'd0);
        chk("midrst_id_pc", 32'(id_pc), 32'd0);
        #1;
        rst = 1'b0;
        mem[4] = 16'h8004;
        for (int i = 0; i < 5; i++) push_a(8'(i));
        @(negedge clk);
        chk("restart_imem_en", 32'(imem_en), 32'd1);
        chk("restart_imem_addr", 32'(imem_addr), 32'h00);

        // Jump at address 4: word 5 must never reach decode.
        wait_level("drain_to_jump", 1'b0, 0, 40);
        chk("jump_wait_set", 32'(jump_wait), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("jw_id_valid", 32'(id_valid), 32'd0);
            chk("jw_imem_en", 32'(imem_en), 32'd0);
            chk("jw_held", 32'(jump_wait), 32'd1);
        end
        for (int i = 0; i < 16; i++) push_a(8'(8'h20 + i));
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 8'h20;
        @(negedge clk);
        chk("redir_cycle_jw", 32'(jump_wait), 32'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        @(negedge clk);
        chk("redir_imem_en", 32'(imem_en), 32'd1);
        chk("redir_imem_addr", 32'(imem_addr), 32'h20);
        chk("redir_jw_clear", 32'(jump_wait), 32'd0);
        @(negedge clk);
        chk("redir_not_yet", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("redir_valid_r3", 32'(id_valid), 32'd1);

        // Redirect without a pending jump must be ignored.
        wait_level("drain_to_stray", 1'b0, 12, 40);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 8'h80;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("stray_jw", 32'(jump_wait), 32'd0);
        wait_level("drain_after_stray", 1'b0, 0, 40);
        @(posedge clk);
        #1;
        id_ready = 1'b0;

        // Second instance: PC wrap from RESET_PC = FE.
        q_b.push_back('{pc: 8'hFE, inst: 16'h00FE});
        q_b.push_back('{pc: 8'hFF, inst: 16'h00FF});
        q_b.push_back('{pc: 8'h00, inst: 16'h0000});
        q_b.push_back('{pc: 8'h01, inst: 16'h0001});
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        id_ready_b = 1'b1;
        @(negedge clk);
        chk("b_first_imem_en", 32'(imem_en_b), 32'd1);
        chk("b_first_imem_addr", 32'(imem_addr_b), 32'hFE);
        wait_level("drain_b", 1'b1, 0, 40);
        @(posedge clk);
        #1;
        id_ready_b = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
